// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode, ALU and selector encodings for the multicycle control unit
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB
  } estado_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/control_salidas.sv
// control_salidas: combinational state-to-control-vector decode, forced to zero during reset
module control_salidas
  import mips_pkg::*;
(
  input  logic    rst,
  input  estado_t st,
  output ctrl_t   c
);
  // Moore decode; unlisted fields and unreachable codes stay zero
  always_comb begin
    c = '0;
    if (!rst) begin
      case (st)
        FETCH: begin
          c.mem_read  = 1'b1;
          c.ir_write  = 1'b1;
          c.alu_src_b = SRCB_4;
          c.alu_op    = ALU_ADD;
          c.pc_write  = 1'b1;
          c.pc_source = PC_ALU;
        end
        DECODE: begin
          c.alu_src_b = SRCB_IMM2;
          c.alu_op    = ALU_ADD;
        end
        MEM_ADDR, ADDI_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end
        MEM_READ: begin
          c.mem_read = 1'b1;
          c.iord     = 1'b1;
        end
        MEM_WB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          c.mem_write = 1'b1;
          c.iord      = 1'b1;
        end
        EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_B;
          c.alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        BRANCH: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = SRCB_B;
          c.alu_op        = ALU_SUB;
          c.pc_write_cond = 1'b1;
          c.pc_source     = PC_ALUOUT;
        end
        JUMP: begin
          c.pc_write  = 1'b1;
          c.pc_source = PC_JUMP;
        end
        ADDI_WB: c.reg_write = 1'b1;
        default: c = '0;
      endcase
    end
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS32 main control FSM with retired-instruction counter
module unidad_control_multiciclo
  import mips_pkg::*;
#(
  parameter int SIZEOP      = 6,
  parameter int SIZE_ALU_OP = 2,
  parameter int S_EST       = 4,
  parameter int S_CNT       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SIZEOP-1:0]      opcode,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [SIZE_ALU_OP-1:0] AluOP,
  output logic [1:0]             PCSource,
  output logic [S_EST-1:0]       estado,
  output logic                   op_invalida,
  output logic [S_CNT-1:0]       instr_cnt
);
  estado_t           state_q, state_d;
  logic [S_CNT-1:0]  cnt_q, cnt_d;
  logic [5:0]        op;
  logic              op_ok, retire;
  ctrl_t             c;
  assign op = 6'(opcode);
  // Next state, retire detection and the Mealy invalid-opcode flag
  always_comb begin
    op_ok       = op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_J || op == OP_ADDI;
    retire      = state_q inside {MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB};
    cnt_d       = retire ? cnt_q + S_CNT'(1) : cnt_q;
    op_invalida = !rst && state_q == DECODE && !op_ok;
    state_d     = FETCH;
    case (state_q)
      FETCH:     state_d = DECODE;
      DECODE:    state_d = (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                           op == OP_R    ? EXEC :
                           op == OP_BEQ  ? BRANCH :
                           op == OP_J    ? JUMP :
                           op == OP_ADDI ? ADDI_EXEC : FETCH;
      MEM_ADDR:  state_d = op == OP_LW ? MEM_READ : op == OP_SW ? MEM_WRITE : FETCH;
      MEM_READ:  state_d = MEM_WB;
      EXEC:      state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      default:   state_d = FETCH;
    endcase
  end
  // State register and counter with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  control_salidas u_salidas (.rst(rst), .st(state_q), .c(c));
  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.iord;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign IRWrite     = c.ir_write;
  assign MemtoReg    = c.mem_to_reg;
  assign RegDst      = c.reg_dst;
  assign RegWrite    = c.reg_write;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign AluOP       = SIZE_ALU_OP'(c.alu_op);
  assign PCSource    = c.pc_source;
  assign estado      = S_EST'(state_q);
  assign instr_cnt   = cnt_q;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed checks of the multicycle control FSM
module tb_unidad_control_multiciclo;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, op_invalida;
  logic [1:0] ALUSrcB, AluOP, PCSource;
  logic [3:0] estado;
  logic [2:0] instr_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.S_CNT(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOP(AluOP),
    .PCSource(PCSource), .estado(estado), .op_invalida(op_invalida),
    .instr_cnt(instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'b000000;
    tick();
    tick();
    chk("rst_estado", estado, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_cnt", instr_cnt, 0);
    rst = 1'b0;
    #1;
    chk("f_memread", MemRead, 1);
    chk("f_irwrite", IRWrite, 1);
    chk("f_pcwrite", PCWrite, 1);
    chk("f_srcb", ALUSrcB, 2'b01);
    chk("f_cnt", instr_cnt, 0);
    // lw
    opcode = 6'b100011;
    chk("lw0_aluop", AluOP, 0);
    tick();
    chk("lw1_estado", estado, 1);
    chk("lw1_aluop", AluOP, 0);
    chk("lw1_srcb", ALUSrcB, 2'b11);
    chk("lw1_inv", op_invalida, 0);
    tick();
    chk("lw2_estado", estado, 2);
    chk("lw2_aluop", AluOP, 0);
    chk("lw2_srcb", ALUSrcB, 2'b10);
    chk("lw2_srca", ALUSrcA, 1);
    tick();
    chk("lw3_estado", estado, 3);
    chk("lw3_memread", MemRead, 1);
    chk("lw3_iord", IorD, 1);
    chk("lw3_regwrite", RegWrite, 0);
    tick();
    chk("lw4_estado", estado, 4);
    chk("lw4_regwrite", RegWrite, 1);
    chk("lw4_memtoreg", MemtoReg, 1);
    chk("lw4_regdst", RegDst, 0);
    tick();
    chk("lw5_estado", estado, 0);
    chk("lw5_regwrite", RegWrite, 0);
    chk("lw_cnt", instr_cnt, 1);
    // R-type
    opcode = 6'b000000;
    tick();
    chk("r1_estado", estado, 1);
    tick();
    chk("r2_estado", estado, 6);
    chk("r2_aluop", AluOP, 2'b10);
    chk("r2_srcb", ALUSrcB, 2'b00);
    tick();
    chk("r3_estado", estado, 7);
    chk("r3_regdst", RegDst, 1);
    chk("r3_regwrite", RegWrite, 1);
    chk("r3_memtoreg", MemtoReg, 0);
    tick();
    chk("r4_estado", estado, 0);
    chk("r_cnt", instr_cnt, 2);
    // beq
    opcode = 6'b000100;
    tick();
    chk("b1_estado", estado, 1);
    tick();
    chk("b2_estado", estado, 8);
    chk("b2_aluop", AluOP, 2'b01);
    chk("b2_pcwc", PCWriteCond, 1);
    chk("b2_pcsrc", PCSource, 2'b01);
    chk("b2_pcwrite", PCWrite, 0);
    tick();
    chk("b3_estado", estado, 0);
    chk("b_cnt", instr_cnt, 3);
    // j
    opcode = 6'b000010;
    tick();
    chk("j1_estado", estado, 1);
    tick();
    chk("j2_estado", estado, 9);
    chk("j2_pcsrc", PCSource, 2'b10);
    chk("j2_pcwrite", PCWrite, 1);
    tick();
    chk("j3_estado", estado, 0);
    chk("j_cnt", instr_cnt, 4);
    // invalid opcode
    opcode = 6'b111111;
    chk("inv0_flag", op_invalida, 0);
    tick();
    chk("inv1_estado", estado, 1);
    chk("inv1_flag", op_invalida, 1);
    tick();
    chk("inv2_estado", estado, 0);
    chk("inv2_flag", op_invalida, 0);
    chk("inv_cnt", instr_cnt, 4);
    // addi
    opcode = 6'b001000;
    tick();
    chk("a1_estado", estado, 1);
    tick();
    chk("a2_estado", estado, 10);
    chk("a2_srcb", ALUSrcB, 2'b10);
    chk("a2_aluop", AluOP, 0);
    tick();
    chk("a3_estado", estado, 11);
    chk("a3_regwrite", RegWrite, 1);
    chk("a3_regdst", RegDst, 0);
    tick();
    chk("a4_estado", estado, 0);
    chk("a_cnt", instr_cnt, 5);
    // sw
    opcode = 6'b101011;
    tick();
    tick();
    chk("s2_estado", estado, 2);
    tick();
    chk("s3_estado", estado, 5);
    chk("s3_memwrite", MemWrite, 1);
    chk("s3_iord", IorD, 1);
    chk("s3_memread", MemRead, 0);
    tick();
    chk("s4_estado", estado, 0);
    chk("s_cnt", instr_cnt, 6);
    // reset during MEM_READ of lw
    opcode = 6'b100011;
    tick();
    tick();
    tick();
    chk("rl_estado", estado, 3);
    rst = 1'b1;
    #1;
    chk("rl_gate_memread", MemRead, 0);
    chk("rl_gate_iord", IorD, 0);
    tick();
    chk("rl_after_estado", estado, 0);
    chk("rl_after_regwrite", RegWrite, 0);
    chk("rl_after_cnt", instr_cnt, 0);
    rst = 1'b0;
    // eight sw wrap the 3-bit counter back to zero
    opcode = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      tick();
      tick();
      tick();
      tick();
      chk("wrap_estado", estado, 0);
      chk("wrap_cnt", instr_cnt, (i + 1) % 8);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
